spi_ram_ctrl: RTL and testbench

Command decoder and access scheduler between the SPI slave and the single-port RAM. It interprets 10-bit SPI frames (rx_data[9:8] = opcode, rx_data[7:0] = payload), holds the write and read address pointers, and issues RAM cycles. A second on-chip host port shares the same RAM through round-robin arbitration. Read results return to the SPI slave on tx_data/tx_valid and to the host on host_rdata/host_rvalid.

---
 rtl/spi_ram_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Command decoder and access scheduler between the SPI slave, an on-chip host
// port and a single-port RAM. The SPI side and the host side share the RAM
// through round-robin arbitration, and all RAM accesses are strictly serialized.
module spi_ram_ctrl #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic                 busy,
  output logic                 err_seq
);

  localparam int unsigned OP_W = 2;
  localparam logic [OP_W-1:0] OP_SET_WA = 2'b00;
  localparam logic [OP_W-1:0] OP_WRITE  = 2'b01;
  localparam logic [OP_W-1:0] OP_SET_RA = 2'b10;
  localparam logic [OP_W-1:0] OP_READ   = 2'b11;

  // The address width and the RAM depth must describe the same memory
  if (MEM_DEPTH != (32'd1 << ADDR_SIZE)) begin : g_depth_check
    $error("spi_ram_ctrl: MEM_DEPTH must equal 2**ADDR_SIZE");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;
  typedef enum logic {OWN_SPI, OWN_HOST} owner_t;

  state_t state_q, state_d;
  owner_t last_owner;

  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_seen, rd_seen;
  logic                 spi_pend, spi_we;
  logic [ADDR_SIZE-1:0] spi_addr;
  logic [DATA_W-1:0]    spi_wdata;

  logic                 frame_acc_c;
  logic [OP_W-1:0]      opcode_c;
  logic [DATA_W-1:0]    payload_c;
  logic                 grant_spi_c, grant_host_c;

  assign frame_acc_c = rx_valid & ~rx_valid_q;
  assign opcode_c    = rx_data[9:8];
  assign payload_c   = rx_data[DATA_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and round-robin grant decision; on a tie the last owner yields
  always_comb begin
    state_d      = state_q;
    grant_spi_c  = 1'b0;
    grant_host_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (spi_pend && host_req) begin
          if (last_owner == OWN_HOST) grant_spi_c  = 1'b1;
          else                        grant_host_c = 1'b1;
        end else if (spi_pend) begin
          grant_spi_c = 1'b1;
        end else if (host_req) begin
          grant_host_c = 1'b1;
        end
        if (grant_spi_c || grant_host_c) state_d = ACCESS;
      end
      ACCESS:  state_d = ram_we ? IDLE : RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SPI frame decode: pointers, pending command and sequence errors
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_seen    <= 1'b0;
      rd_seen    <= 1'b0;
      spi_pend   <= 1'b0;
      spi_we     <= 1'b0;
      spi_addr   <= '0;
      spi_wdata  <= '0;
      err_seq    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (grant_spi_c) spi_pend <= 1'b0;
      if (frame_acc_c) begin
        case (opcode_c)
          OP_SET_WA: begin
            wr_addr <= ADDR_SIZE'(payload_c);
            wr_seen <= 1'b1;
          end
          OP_WRITE: begin
            spi_we    <= 1'b1;
            spi_addr  <= wr_addr;
            spi_wdata <= payload_c;
            spi_pend  <= 1'b1;
            if (!wr_seen || (spi_pend && !grant_spi_c)) err_seq <= 1'b1;
          end
          OP_SET_RA: begin
            rd_addr <= ADDR_SIZE'(payload_c);
            rd_seen <= 1'b1;
          end
          default: begin
            spi_we   <= 1'b0;
            spi_addr <= rd_addr;
            spi_pend <= 1'b1;
            rd_seen  <= 1'b0;
            if (!rd_seen || (spi_pend && !grant_spi_c)) err_seq <= 1'b1;
          end
        endcase
      end
    end
  end

  // RAM cycle issue: a grant in IDLE presents exactly one RAM cycle next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      host_gnt   <= 1'b0;
      last_owner <= OWN_HOST;
      busy       <= 1'b0;
    end else begin
      ram_en   <= grant_spi_c | grant_host_c;
      host_gnt <= grant_host_c;
      busy     <= (state_d != IDLE);
      if (grant_spi_c) begin
        ram_we     <= spi_we;
        ram_addr   <= spi_addr;
        ram_wdata  <= spi_wdata;
        last_owner <= OWN_SPI;
      end else if (grant_host_c) begin
        ram_we     <= host_we;
        ram_addr   <= host_addr;
        ram_wdata  <= host_wdata;
        last_owner <= OWN_HOST;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

  // Read return: last_owner still names the owner of the read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      if (frame_acc_c) tx_valid <= 1'b0;
      if (state_q == RD_WAIT) begin
        if (last_owner == OWN_SPI) begin
          tx_data  <= ram_rdata;
          tx_valid <= 1'b1;
        end else begin
          host_rdata  <= ram_rdata;
          host_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl with a behavioural single-port RAM.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy, err_seq;

  int n_checks = 0;
  int n_errors = 0;

  // RAM model bookkeeping
  logic [7:0] mem [256];
  int         n_wr = 0, n_rd = 0, n_overlap = 0;
  logic [7:0] last_wr_addr = 8'h00, last_wr_data = 8'h00, last_rd_addr = 8'h00;
  logic       ram_en_prev = 1'b0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .err_seq(err_seq)
  );

  // Single-port RAM with one-cycle read latency, plus access logging
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        n_wr = n_wr + 1;
        last_wr_addr = ram_addr;
        last_wr_data = ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
        n_rd = n_rd + 1;
        last_rd_addr = ram_addr;
      end
    end
    if (ram_en && ram_en_prev) n_overlap = n_overlap + 1;
    ram_en_prev = ram_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; host_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Drive a frame for one cycle; returns at the negedge after the accepting edge
  task automatic send_frame(input logic [9:0] f);
    @(negedge clk);
    rx_data = f; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int w0, r0, ov0, hv, tr;
    logic txp;
    logic [7:0] hrd;

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Reset state
    tick(2);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_seq, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // Write A7 to 05, read it back over SPI
    w0 = n_wr;
    send_frame(10'h005);
    send_frame(10'h1A7);
    tick(3);
    check("t1_wr_count", n_wr - w0, 1);
    check("t1_wr_addr", last_wr_addr, 8'h05);
    check("t1_wr_data", last_wr_data, 8'hA7);
    send_frame(10'h205);
    send_frame(10'h300);
    check("t1_txv_n1", tx_valid, 0);
    tick(1);
    check("t1_ram_en_n2", ram_en, 1);
    check("t1_ram_we_n2", ram_we, 0);
    check("t1_ram_addr_n2", ram_addr, 8'h05);
    tick(1);
    check("t1_txv_n3", tx_valid, 0);
    check("t1_busy_n3", busy, 1);
    tick(1);
    check("t1_txv_n4", tx_valid, 1);
    check("t1_txd_n4", tx_data, 8'hA7);
    check("t1_err", err_seq, 0);

    // Read without a preceding read-address frame
    do_reset();
    r0 = n_rd;
    send_frame(10'h300);
    check("t2_err_set", err_seq, 1);
    tick(4);
    check("t2_rd_count", n_rd - r0, 1);
    check("t2_rd_addr", last_rd_addr, 8'h00);
    tick(10);
    check("t2_err_sticky", err_seq, 1);
    do_reset();
    @(negedge clk);
    check("t2_err_cleared", err_seq, 0);

    // SPI and host contend in the same IDLE cycle: SPI first, then host
    do_reset();
    @(negedge clk);
    rx_data = 10'h155; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
    @(negedge clk);
    check("t3_spi_en", ram_en, 1);
    check("t3_spi_we", ram_we, 1);
    check("t3_spi_wdata", ram_wdata, 8'h55);
    check("t3_gnt_early1", host_gnt, 0);
    @(negedge clk);
    check("t3_gnt_early2", host_gnt, 0);
    @(negedge clk);
    check("t3_host_gnt", host_gnt, 1);
    check("t3_host_addr", ram_addr, 8'h10);
    check("t3_host_wdata", ram_wdata, 8'h3C);
    host_req = 1'b0;
    @(negedge clk);
    rx_data = 10'h1AA; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("t3_spi2_wdata", ram_wdata, 8'hAA);
    rx_data = 10'h1BB; rx_valid = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h11; host_wdata = 8'hC3;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("t3_rr_host_gnt", host_gnt, 1);
    check("t3_rr_host_addr", ram_addr, 8'h11);
    check("t3_rr_host_wdata", ram_wdata, 8'hC3);
    host_req = 1'b0;
    @(negedge clk);
    check("t3_rr_gnt_drop", host_gnt, 0);
    @(negedge clk);
    check("t3_rr_spi_en", ram_en, 1);
    check("t3_rr_spi_wdata", ram_wdata, 8'hBB);

    // Frame held high for 12 cycles is accepted once
    tick(3);
    w0 = n_wr;
    @(negedge clk);
    rx_data = 10'h1FF; rx_valid = 1'b1;
    tick(12);
    rx_valid = 1'b0;
    tick(6);
    check("t4_wr_count", n_wr - w0, 1);
    check("t4_wr_data", last_wr_data, 8'hFF);

    // Host read and SPI read of the same location in contention
    do_reset();
    send_frame(10'h005);
    send_frame(10'h1A7);
    tick(3);
    send_frame(10'h205);
    r0 = n_rd;
    ov0 = n_overlap;
    @(negedge clk);
    rx_data = 10'h300; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    hv = 0; tr = 0; txp = 1'b0; hrd = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_gnt) host_req = 1'b0;
      if (host_rvalid) begin
        hv++;
        hrd = host_rdata;
      end
      if (tx_valid && !txp) tr++;
      txp = tx_valid;
    end
    check("t5_host_rvalid_cnt", hv, 1);
    check("t5_host_rdata", hrd, 8'hA7);
    check("t5_tx_rise_cnt", tr, 1);
    check("t5_tx_data", tx_data, 8'hA7);
    check("t5_rd_count", n_rd - r0, 2);
    check("t5_no_overlap", n_overlap - ov0, 0);

    // Reset during RD_WAIT of an SPI read
    do_reset();
    send_frame(10'h205);
    send_frame(10'h300);
    tick(2);
    check("t6_busy_rdwait", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_txv_after_rst", tx_valid, 0);
    check("t6_busy_after_rst", busy, 0);
    check("t6_ram_en_after_rst", ram_en, 0);
    rst = 1'b0;
    tick(4);
    check("t6_txv_stays_low", tx_valid, 0);
    check("t6_no_host_rvalid", host_rvalid, 0);
    r0 = n_rd;
    send_frame(10'h300);
    tick(3);
    check("t6_rd_ptr_zero", last_rd_addr, 8'h00);
    check("t6_rd_count", n_rd - r0, 1);
    check("t6_tx_valid", tx_valid, 1);
    check("t6_tx_data", tx_data, 8'hFF);
    send_frame(10'h1CC);
    tick(3);
    check("t6_wr_ptr_zero", last_wr_addr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
